instr_fetch: RTL

Instruction-fetch stage of the pipelined LEGv8 core: owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It is the consumer of the decode stage's branch controls (BrTaken, UncondBr). On a taken branch it computes the target, redirects the PC and squashes the wrong-path instruction. It also honours the hazard unit's stall and keeps a saturating count of redirects.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/branch_target.sv | 30 +++
 rtl/instr_fetch.sv | 72 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared across the LEGv8 pipeline.
//   INSTR_W    instruction word width
//   NOP_INSTR  bubble instruction; its opcode hits the decoder default, so no writes
//   OPC_*      11-bit opcode bases for the B and CB formats
//   br_fmt_e   selects which branch-offset field is used
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

    // B occupies opcode range 0A0-0BF; CBZ 5A0-5A7; CBNZ 5A8-5AF.
    localparam logic [10:0] OPC_B    = 11'h0A0;
    localparam logic [10:0] OPC_CBZ  = 11'h5A0;
    localparam logic [10:0] OPC_CBNZ = 11'h5A8;

    typedef enum logic {
        FMT_CB = 1'b0,
        FMT_B  = 1'b1
    } br_fmt_e;

endpackage

// File: rtl/branch_target.sv
// branch_target: combinational branch-target computation.
//   pc      PC of the branch instruction
//   instr   branch instruction word
//   uncond  1: B-format imm26, 0: CB-format imm19
//   target  pc + (sign-extended immediate << 2), modulo 2^ADDR_W
module branch_target
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               uncond,
    output logic [ADDR_W-1:0]  target
);

    logic [ADDR_W-1:0] offset;
    br_fmt_e           fmt;

    always_comb begin
        fmt    = br_fmt_e'(uncond);
        offset = '0;
        if (fmt == FMT_B)
            offset = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
        else
            offset = {{(ADDR_W-21){instr[23]}}, instr[23:5], 2'b00};
        target = pc + offset;
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage -- PC register, IF/ID pipeline register and a
// saturating count of taken redirects.
//   clk, reset         clock; synchronous active-low reset
//   stall              hazard hold: PC, IF/ID and counter freeze
//   BrTaken, UncondBr  decode-stage branch controls
//   br_valid, br_pc, br_instr  decode-stage instruction being resolved
//   imem_addr, imem_rdata      instruction-memory port (combinational read)
//   if_id_pc, if_id_instr, if_id_valid  IF/ID register outputs
//   redirect_cnt       number of taken redirects, saturating at all-ones
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int unsigned         CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               BrTaken,
    input  logic               UncondBr,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_pc,
    input  logic [INSTR_W-1:0] br_instr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   redirect_cnt
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              redirect;

    branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
        .pc     (br_pc),
        .instr  (br_instr),
        .uncond (UncondBr),
        .target (target)
    );

    // A bubble in decode (br_valid=0) must never redirect; a stalled
    // branch is re-presented by decode, so it is ignored here.
    assign redirect  = BrTaken & br_valid & ~stall;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc           <= RESET_PC;
            if_id_pc     <= '0;
            if_id_instr  <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            redirect_cnt <= '0;
        end else if (!stall) begin
            if_id_pc <= pc;
            if (redirect) begin
                pc          <= target;
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
                if (redirect_cnt != '1)
                    redirect_cnt <= redirect_cnt + 1'b1;
            end else begin
                pc          <= pc + ADDR_W'(4);
                if_id_instr <= imem_rdata;
                if_id_valid <= 1'b1;
            end
        end
    end

endmodule
